// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV64M multiply/divide execute unit.
//   Shift-add multiply and restoring divide, one bit per clock, with a
//   start/busy/done handshake. Divide-by-zero and signed overflow complete
//   straight from IDLE without iterating.
// Ports:
//   clk       in   system clock, all state changes on the rising edge
//   rst_n     in   synchronous active-low reset
//   start     in   operation request, only accepted in IDLE
//   funct3    in   000 MUL 001 MULH 010 MULHSU 011 MULHU
//                  100 DIV 101 DIVU 110 REM 111 REMU
//   operand_a in   rs1: multiplicand / dividend
//   operand_b in   rs2: multiplier / divisor
//   busy      out  high whenever the unit is not IDLE
//   done      out  one-cycle pulse, result valid from this cycle on
//   result    out  registered result, held until the next accepted start
module muldiv_unit #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t            state_reg, state_next;
  logic [2:0]        funct3_reg;
  logic              sign_a_reg, sign_b_reg;
  logic [CW-1:0]     count_reg;
  // Multiply: {partial product high, multiplier}. Divide: {remainder, quotient}.
  logic [2*XLEN-1:0] acc_reg;
  // Multiplicand for multiply, divisor for divide.
  logic [XLEN-1:0]   addend_reg;
  logic [XLEN-1:0]   result_reg;

  // ---------------- accept-time decode ----------------
  logic            is_div_in, a_signed_in, b_signed_in;
  logic            sign_a_in, sign_b_in;
  logic [XLEN-1:0] abs_a_in, abs_b_in;
  logic            div_zero_in, ovf_in, special_in;
  logic [XLEN-1:0] special_res_in;

  always_comb begin
    is_div_in   = funct3[2];
    a_signed_in = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                  (funct3 == 3'b100) || (funct3 == 3'b110);
    b_signed_in = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    sign_a_in   = a_signed_in && operand_a[XLEN-1];
    sign_b_in   = b_signed_in && operand_b[XLEN-1];
    // Negating the most negative value yields 2^(XLEN-1), which is the
    // correct unsigned magnitude.
    abs_a_in    = sign_a_in ? (~operand_a + 1'b1) : operand_a;
    abs_b_in    = sign_b_in ? (~operand_b + 1'b1) : operand_b;
    div_zero_in = is_div_in && (operand_b == '0);
    // Signed DIV/REM only (funct3 100/110): most-negative / -1.
    ovf_in      = is_div_in && !funct3[0] &&
                  (operand_a == {1'b1, {(XLEN-1){1'b0}}}) && (operand_b == '1);
    special_in  = div_zero_in || ovf_in;
    // funct3[1] distinguishes remainder from quotient.
    if (div_zero_in)
      special_res_in = funct3[1] ? operand_a : '1;
    else
      special_res_in = funct3[1] ? '0 : operand_a;
  end

  // ---------------- per-iteration steps ----------------
  logic [XLEN:0]     add_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     trial;
  logic [XLEN+1:0]   diff;
  logic [2*XLEN-1:0] div_next;

  always_comb begin
    add_sum  = {1'b0, acc_reg[2*XLEN-1:XLEN]} + {1'b0, addend_reg};
    mul_next = acc_reg[0] ? {add_sum, acc_reg[XLEN-1:1]}
                          : {1'b0, acc_reg[2*XLEN-1:1]};
    // Remainder after the left shift needs one extra bit because an
    // unsigned remainder can reach 2^XLEN-2 before doubling.
    trial    = acc_reg[2*XLEN-1:XLEN-1];
    diff     = {1'b0, trial} - {2'b00, addend_reg};
    div_next = diff[XLEN+1] ? {acc_reg[2*XLEN-2:0], 1'b0}
                            : {diff[XLEN-1:0], acc_reg[XLEN-2:0], 1'b1};
  end

  // ---------------- sign fix-up and result select ----------------
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix, fix_result;

  always_comb begin
    prod_fix = (sign_a_reg ^ sign_b_reg) ? (~acc_reg + 1'b1) : acc_reg;
    quot_fix = (sign_a_reg ^ sign_b_reg) ? (~acc_reg[XLEN-1:0] + 1'b1)
                                         : acc_reg[XLEN-1:0];
    rem_fix  = sign_a_reg ? (~acc_reg[2*XLEN-1:XLEN] + 1'b1)
                          : acc_reg[2*XLEN-1:XLEN];
    case (funct3_reg)
      3'b000:                 fix_result = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_result = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_result = quot_fix;
      default:                fix_result = rem_fix;
    endcase
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (start) state_next = special_in ? DONE : CALC;
      CALC: if (count_reg == CW'(XLEN-1)) state_next = FIX;
      FIX:  state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      funct3_reg <= '0;
      sign_a_reg <= 1'b0;
      sign_b_reg <= 1'b0;
      count_reg  <= '0;
      acc_reg    <= '0;
      addend_reg <= '0;
      result_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            funct3_reg <= funct3;
            sign_a_reg <= sign_a_in;
            sign_b_reg <= sign_b_in;
            count_reg  <= '0;
            acc_reg    <= {{XLEN{1'b0}}, (is_div_in ? abs_a_in : abs_b_in)};
            addend_reg <= is_div_in ? abs_b_in : abs_a_in;
            if (special_in) result_reg <= special_res_in;
          end
        end
        CALC: begin
          acc_reg   <= funct3_reg[2] ? div_next : mul_next;
          count_reg <= count_reg + 1'b1;
        end
        FIX:     result_reg <= fix_result;
        default: ;
      endcase
    end
  end

  assign busy   = (state_reg != IDLE);
  assign done   = (state_reg == DONE);
  assign result = result_reg;

endmodule
